vdp_host_port: RTL and testbench
================================

# vdp_host_port

Host-side write port into video RAM, sitting directly upstream of the VRAM that the display controller fetches from. The host CPU programs a 16-bit VRAM pointer and streams data bytes through a small register file. Each byte is queued with its target address in a FIFO and committed to VRAM only in character-cell dot slots that the display fetch sequence leaves idle, so host writes never disturb scan-out.

## Interface
Parameters:
- FIFO_DEPTH, 4 — queued writes; power of two, ≥2
- DEF_STEP, 8'h01 — pointer increment after each data write, loaded at reset

Ports:
- clk  in  1  dot clock, shared with display timing
- reset  in  1  asynchronous, active-low
- dot  in  3  current dot index within the 8-dot character cell (column[2:0] of display timing)
- cpu_cs  in  1  register access strobe, one access per clk while high
- cpu_we  in  1  1 = write, 0 = read
- cpu_reg  in  2  register select
- cpu_wdata  in  8  write data
- cpu_rdata  out  8  registered read data
- busy  out  1  FIFO full
- vram_addr  out  16  address of FIFO head entry (16'h0000 when empty)
- vram_wdata  out  8  data of FIFO head entry (8'h00 when empty)
- vram_we  out  1  VRAM write strobe, one clk per committed entry

## Operation
- Registers: 0 = pointer[7:0], 1 = pointer[15:8], 2 = data, 3 = status/step.
- Write reg 0/1: load that pointer byte; other byte unchanged.
- Write reg 2: push {pointer, cpu_wdata}; pointer <= pointer + step, mod 2^16 (16'hFFFF + 1 wraps to 16'h0000). If FIFO full and no pop that cycle: entry dropped, pointer NOT incremented, overflow <= 1.
- Write reg 3: step <= cpu_wdata (step 0 legal: repeated writes to one address).
- Read reg 0/1: pointer bytes. Read reg 2: 8'h00. Read reg 3: {5'b0, overflow, full, empty}; overflow clears on the read edge (cpu_rdata carries the pre-clear value).
- Changing pointer or step never affects entries already queued.
- Commit slots: dot == 3'd5 or dot == 3'd7 (dots 0–4 belong to display fetch). vram_we = slot && !empty, combinational from dot and registered FIFO state; the head is popped on that edge.
- Simultaneous push and pop: both take effect; count unchanged; a push while full is accepted if a pop occurs the same edge.
- FIFO strictly in order; no write coalescing.
- Reset (async assert, sync release inside block not required): FIFO empty, pointer 16'h0000, step DEF_STEP, overflow 0, cpu_rdata 8'h00, busy 0, vram_we 0, vram_addr 16'h0000, vram_wdata 8'h00. Reset mid-queue discards all pending entries.

## Timing
- All state updates on rising clk; reset asynchronous.
- Register write takes effect on the edge with cpu_cs & cpu_we; visible to a read issued the next cycle.
- cpu_rdata updated on the edge with cpu_cs & !cpu_we; holds otherwise. One-cycle read latency.
- Push to empty FIFO: entry is head the cycle after the push edge; committed at the first following cycle with dot ∈ {5,7}; worst case 6 clk after push, best case 1.
- Sustained drain rate: 2 entries per 8 clk; host may push at most 1 per clk, so bursts beyond FIFO_DEPTH must poll busy or status.
- busy and status full/empty reflect registered count; they change the cycle after the push/pop edge.

## Test plan
- Reset, then read reg 3 -> cpu_rdata 8'h01 (empty); read reg 0/1 -> 8'h00; vram_we low through 16 dot cycles.
- Write reg1=8'h60, reg0=8'h00, reg2=8'hAA, 8'hBB -> vram_we pulses at the next dot 5 and dot 7 with (16'h6000,8'hAA) then (16'h6001,8'hBB); pointer reads back 16'h6002.
- Pointer 16'hFFFF, step 8'h02, write data 8'h11 -> committed to 16'hFFFF; pointer reads 16'h0001.
- With dot held at 3'd0, push FIFO_DEPTH+1 bytes -> busy high after 4th push, 5th dropped, pointer advanced only 4 steps, status 8'h06; second status read 8'h02.
- Push on the same edge as a slot pop while full -> entry accepted, busy stays 1, no overflow; all entries emerge in push order.
- Assert reset with 3 entries queued -> vram_we low immediately, after release status 8'h01 and no further VRAM writes.

Source files
------------

// File: rtl/vdp_host_port_if.sv
// Host CPU register bus and VRAM write-side signals of the VDP host port.
interface vdp_host_port_if;
    logic        cpu_cs;
    logic        cpu_we;
    logic [1:0]  cpu_reg;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        busy;
    logic [15:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we;

    modport master (
        output cpu_cs, cpu_we, cpu_reg, cpu_wdata,
        input  cpu_rdata, busy, vram_addr, vram_wdata, vram_we
    );

    modport slave (
        input  cpu_cs, cpu_we, cpu_reg, cpu_wdata,
        output cpu_rdata, busy, vram_addr, vram_wdata, vram_we
    );
endinterface

// File: rtl/vdp_host_port.sv
// Host write port into VRAM: pointer/step register file feeding an in-order
// write FIFO that drains only in the idle dot slots (5 and 7) of each cell.
module vdp_host_port #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  DEF_STEP   = 8'h01
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        dot,
    vdp_host_port_if.slave    host
);
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        REG_PTR_LO = 2'd0,
        REG_PTR_HI = 2'd1,
        REG_DATA   = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    logic [23:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic [CW-1:0] count;
    logic [15:0]   ptr;
    logic [7:0]    step;
    logic          overflow;
    logic [7:0]    rdata_q;

    reg_sel_e      sel;
    logic          wr_en;
    logic          rd_en;
    logic          empty;
    logic          full;
    logic          slot;
    logic          pop;
    logic          push_req;
    logic          push;
    logic          drop;
    logic [23:0]   head;

    // Decode host access, FIFO status and the commit-slot pop/push/drop decisions.
    always_comb begin
        sel      = reg_sel_e'(host.cpu_reg);
        wr_en    = host.cpu_cs & host.cpu_we;
        rd_en    = host.cpu_cs & ~host.cpu_we;
        empty    = (count == '0);
        full     = (count == DEPTH_C);
        slot     = (dot == 3'd5) || (dot == 3'd7);
        pop      = slot & ~empty;
        push_req = wr_en && (sel == REG_DATA);
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push     = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
        head     = mem[rd_idx];
    end

    // FIFO storage; contents are only observed while count marks them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= {ptr, host.cpu_wdata};
        end
    end

    // FIFO indices and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_idx <= '0;
            wr_idx <= '0;
            count  <= '0;
        end else begin
            if (pop)  rd_idx <= rd_idx + 1'b1;
            if (push) wr_idx <= wr_idx + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Pointer, step and sticky overflow register updates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr      <= '0;
            step     <= DEF_STEP;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                case (sel)
                    REG_PTR_LO: ptr[7:0]  <= host.cpu_wdata;
                    REG_PTR_HI: ptr[15:8] <= host.cpu_wdata;
                    REG_DATA:   if (push) ptr <= ptr + {8'h00, step};
                    REG_STATUS: step <= host.cpu_wdata;
                    default:    ptr <= ptr;
                endcase
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (rd_en && (sel == REG_STATUS)) begin
                overflow <= 1'b0;
            end
        end
    end

    // Registered read data; holds its value between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            case (sel)
                REG_PTR_LO: rdata_q <= ptr[7:0];
                REG_PTR_HI: rdata_q <= ptr[15:8];
                REG_DATA:   rdata_q <= 8'h00;
                REG_STATUS: rdata_q <= {5'b0, overflow, full, empty};
                default:    rdata_q <= 8'h00;
            endcase
        end
    end

    assign host.cpu_rdata  = rdata_q;
    assign host.busy       = full;
    assign host.vram_we    = pop;
    assign host.vram_addr  = empty ? 16'h0000 : head[23:8];
    assign host.vram_wdata = empty ? 8'h00    : head[7:0];
endmodule

// File: tb/tb_vdp_host_port.sv
// Self-checking bench for vdp_host_port: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_vdp_host_port;
    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  DSTEP = 8'h01;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] dot;

    vdp_host_port_if bus();

    vdp_host_port #(.FIFO_DEPTH(DEPTH), .DEF_STEP(DSTEP)) dut (
        .clk   (clk),
        .reset (reset),
        .dot   (dot),
        .host  (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    logic [23:0] m_q[$];
    logic [15:0] m_ptr;
    logic [7:0]  m_step;
    logic        m_ovf;
    logic [7:0]  m_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_ptr   = 16'h0000;
        m_step  = DSTEP;
        m_ovf   = 1'b0;
        m_rdata = 8'h00;
    endtask

    // One clock: drive at negedge, check combinational outputs, advance model at posedge,
    // check registered read data at the following negedge.
    task automatic cycle(input logic cs, input logic we, input logic [1:0] rg,
                         input logic [7:0] wd, input logic [2:0] d);
        bit full, empty, pop;
        bus.cpu_cs    = cs;
        bus.cpu_we    = we;
        bus.cpu_reg   = rg;
        bus.cpu_wdata = wd;
        dot           = d;
        #1;
        empty = (m_q.size() == 0);
        full  = (m_q.size() == DEPTH);
        pop   = ((d == 3'd5) || (d == 3'd7)) && !empty;
        chk("vram_we",    32'(bus.vram_we),    32'(pop));
        chk("vram_addr",  32'(bus.vram_addr),  empty ? 32'h0 : 32'(m_q[0][23:8]));
        chk("vram_wdata", 32'(bus.vram_wdata), empty ? 32'h0 : 32'(m_q[0][7:0]));
        chk("busy",       32'(bus.busy),       32'(full));
        @(posedge clk);
        if (cs && !we) begin
            case (rg)
                2'd0: m_rdata = m_ptr[7:0];
                2'd1: m_rdata = m_ptr[15:8];
                2'd2: m_rdata = 8'h00;
                default: begin
                    m_rdata = {5'b0, m_ovf, full, empty};
                    m_ovf   = 1'b0;
                end
            endcase
        end
        if (pop) void'(m_q.pop_front());
        if (cs && we) begin
            case (rg)
                2'd0: m_ptr[7:0]  = wd;
                2'd1: m_ptr[15:8] = wd;
                2'd2: begin
                    if (m_q.size() < DEPTH) begin
                        m_q.push_back({m_ptr, wd});
                        m_ptr = m_ptr + 16'(m_step);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                default: m_step = wd;
            endcase
        end
        @(negedge clk);
        chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(m_rdata));
    endtask

    task automatic wr(input logic [1:0] rg, input logic [7:0] wd, input logic [2:0] d);
        cycle(1'b1, 1'b1, rg, wd, d);
    endtask

    task automatic rd(input logic [1:0] rg, input logic [2:0] d);
        cycle(1'b1, 1'b0, rg, 8'h00, d);
    endtask

    task automatic idle(input logic [2:0] d);
        cycle(1'b0, 1'b0, 2'd0, 8'h00, d);
    endtask

    // Assert reset with dot in a commit slot so a missing reset would show a write strobe.
    task automatic do_reset();
        bus.cpu_cs = 1'b0;
        dot        = 3'd5;
        reset      = 1'b0;
        #1;
        model_clear();
        chk("rst_vram_we",   32'(bus.vram_we),    32'h0);
        chk("rst_vram_addr", 32'(bus.vram_addr),  32'h0);
        chk("rst_vram_data", 32'(bus.vram_wdata), 32'h0);
        chk("rst_busy",      32'(bus.busy),       32'h0);
        chk("rst_rdata",     32'(bus.cpu_rdata),  32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset         = 1'b0;
        dot           = 3'd0;
        bus.cpu_cs    = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_reg   = 2'd0;
        bus.cpu_wdata = 8'h00;
        model_clear();
        @(negedge clk);
        do_reset();

        // Reset state reads and an idle scan with nothing queued
        rd(2'd3, 3'd0); chk("status_after_reset", 32'(bus.cpu_rdata), 32'h01);
        rd(2'd0, 3'd1); chk("ptr_lo_reset", 32'(bus.cpu_rdata), 32'h00);
        rd(2'd1, 3'd2); chk("ptr_hi_reset", 32'(bus.cpu_rdata), 32'h00);
        for (int i = 0; i < 16; i++) idle(3'(i));

        // Two data bytes drained in dots 5 and 7
        wr(2'd1, 8'h60, 3'd0);
        wr(2'd0, 8'h00, 3'd1);
        wr(2'd2, 8'hAA, 3'd2);
        wr(2'd2, 8'hBB, 3'd3);
        idle(3'd4);
        dot = 3'd5; #1;
        chk("pulse1_we",   32'(bus.vram_we),    32'h1);
        chk("pulse1_addr", 32'(bus.vram_addr),  32'h6000);
        chk("pulse1_data", 32'(bus.vram_wdata), 32'hAA);
        idle(3'd5);
        idle(3'd6);
        dot = 3'd7; #1;
        chk("pulse2_addr", 32'(bus.vram_addr),  32'h6001);
        chk("pulse2_data", 32'(bus.vram_wdata), 32'hBB);
        idle(3'd7);
        rd(2'd0, 3'd0); chk("ptr_lo_6002", 32'(bus.cpu_rdata), 32'h02);
        rd(2'd1, 3'd1); chk("ptr_hi_6002", 32'(bus.cpu_rdata), 32'h60);

        // Pointer wrap at 16'hFFFF with step 2
        wr(2'd1, 8'hFF, 3'd0);
        wr(2'd0, 8'hFF, 3'd0);
        wr(2'd3, 8'h02, 3'd0);
        wr(2'd2, 8'h11, 3'd0);
        for (int i = 1; i < 5; i++) idle(3'(i));
        dot = 3'd5; #1;
        chk("wrap_addr", 32'(bus.vram_addr), 32'hFFFF);
        idle(3'd5);
        rd(2'd0, 3'd6); chk("ptr_lo_wrap", 32'(bus.cpu_rdata), 32'h01);
        rd(2'd1, 3'd7); chk("ptr_hi_wrap", 32'(bus.cpu_rdata), 32'h00);

        // Overflow with dot held outside the commit slots
        wr(2'd3, 8'h01, 3'd0);
        wr(2'd0, 8'h00, 3'd0);
        wr(2'd1, 8'h00, 3'd0);
        for (int i = 0; i <= DEPTH; i++) wr(2'd2, 8'(8'h20 + i), 3'd0);
        chk("busy_full", 32'(bus.busy), 32'h1);
        rd(2'd3, 3'd0); chk("status_ovf", 32'(bus.cpu_rdata), 32'h06);
        rd(2'd3, 3'd0); chk("status_ovf_clr", 32'(bus.cpu_rdata), 32'h02);
        rd(2'd0, 3'd0); chk("ptr_after_drop", 32'(bus.cpu_rdata), 32'h04);

        // Push coinciding with a slot pop while full
        wr(2'd2, 8'h77, 3'd5);
        chk("busy_stays", 32'(bus.busy), 32'h1);
        rd(2'd3, 3'd0); chk("status_no_ovf", 32'(bus.cpu_rdata), 32'h02);
        for (int i = 0; i < 16; i++) idle(3'(i));

        // Reset with entries pending
        wr(2'd2, 8'h31, 3'd0);
        wr(2'd2, 8'h32, 3'd1);
        wr(2'd2, 8'h33, 3'd2);
        do_reset();
        rd(2'd3, 3'd0); chk("status_post_reset", 32'(bus.cpu_rdata), 32'h01);
        for (int i = 0; i < 16; i++) idle(3'(i));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            logic [1:0]  rg;
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                r  = $urandom_range(0, 9);
                rg = (r < 4) ? 2'd2 : 2'($urandom_range(0, 3));
                cycle(r < 7, $urandom_range(0, 3) != 0, rg, 8'($urandom), 3'($urandom_range(0, 7)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
